// File: rtl/ppcpu_trace_checker_if.sv
// ---------------------------------------------------------------------------
// ppcpu_trace_checker_if
// Debug trace bundle emitted by the stalled pipeline CPU once per cycle.
//   PC        32  fetch PC
//   IF_INST   32  instruction currently in IF
//   ID_INST   32  instruction currently in ID
//   pcsource   2  next-PC select (0 = PC+4)
//   stall      1  load-use stall request
// Modports: master = CPU side (drives), slave = trace checker (observes).
// ---------------------------------------------------------------------------
interface ppcpu_trace_checker_if;
    logic [31:0] PC;
    logic [31:0] IF_INST;
    logic [31:0] ID_INST;
    logic [1:0]  pcsource;
    logic        stall;

    modport master (output PC, output IF_INST, output ID_INST, output pcsource, output stall);
    modport slave  (input  PC, input  IF_INST, input  ID_INST, input  pcsource, input  stall);
endinterface

// File: rtl/ppcpu_trace_checker.sv
// ---------------------------------------------------------------------------
// ppcpu_trace_checker
// Samples the CPU debug trace every cycle, checks the stall/advance rules,
// keeps a shadow valid pipeline (ID->EXE->MEM->WB) and reports statistics.
//
// Ports
//   Clock       in   single clock, all state changes on posedge
//   Resetn      in   synchronous active-low reset
//   trace       in   ppcpu_trace_checker_if.slave (PC, IF_INST, ID_INST, pcsource, stall)
//   err         out  sticky error flag
//   err_code    out  first error: 1 hold, 2 pc-seq, 3 shift, 4 stall-run, 0 none
//   err_pc      out  PC sampled in the cycle the first error was detected
//   cycle_cnt   out  cycles spent in RUN/ERROR (saturating)
//   stall_cnt   out  stall=1 cycles in RUN/ERROR (saturating)
//   retire_cnt  out  shadow WB-valid cycles (saturating)
//   max_run     out  longest stall run seen, saturating at 255
//
// Configuration
//   TRACE_PC_CHECK_EN  when defined, the pc-seq check (code 2) is enabled.
// ---------------------------------------------------------------------------
module ppcpu_trace_checker #(
    parameter int CW        = 32,
    parameter int MAX_STALL = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    ppcpu_trace_checker_if.slave  trace,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [31:0]           err_pc,
    output logic [CW-1:0]         cycle_cnt,
    output logic [CW-1:0]         stall_cnt,
    output logic [CW-1:0]         retire_cnt,
    output logic [7:0]            max_run
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERROR} state_t;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [7:0]    RUN_LIMIT = 8'(MAX_STALL);

    state_t        state_q, state_d;
    logic [31:0]   prev_pc_q, prev_pc_d;
    logic [31:0]   prev_if_q, prev_if_d;
    logic          prev_stall_q, prev_stall_d;
    logic [1:0]    prev_pcsource_q, prev_pcsource_d;
    logic          id_v_q, id_v_d;
    logic          exe_v_q, exe_v_d;
    logic          mem_v_q, mem_v_d;
    logic          wb_v_q, wb_v_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] retire_cnt_q, retire_cnt_d;
    logic [7:0]    run_q, run_d;
    logic [7:0]    max_run_q, max_run_d;
    logic          err_q, err_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [31:0]   err_pc_q, err_pc_d;
    logic [2:0]    fail_code;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Rule checks against the previous-cycle samples. Evaluated from the
    // highest code down so the lowest failing code is the one left standing.
    always_comb begin
        fail_code = 3'd0;
        // A stall that would push the run past MAX_STALL cycles
        if (trace.stall && (run_q >= RUN_LIMIT)) begin
            fail_code = 3'd4;
        end
        if (!prev_stall_q && (trace.ID_INST != prev_if_q)) begin
            fail_code = 3'd3;
        end
`ifdef TRACE_PC_CHECK_EN
        if (!prev_stall_q && (prev_pcsource_q == 2'd0) && (trace.PC != prev_pc_q + 32'd4)) begin
            fail_code = 3'd2;
        end
`endif
        if (prev_stall_q && ((trace.PC != prev_pc_q) || (trace.IF_INST != prev_if_q))) begin
            fail_code = 3'd1;
        end
    end

`ifndef TRACE_PC_CHECK_EN
    // prev_pcsource is only consumed by the pc-seq check
    logic unused_pcsource;
    assign unused_pcsource = ^prev_pcsource_q;
`endif

    // Next-state logic: IDLE primes the previous-sample registers, RUN and
    // ERROR both advance the shadow pipeline and statistics, only RUN checks.
    always_comb begin
        state_d         = state_q;
        prev_pc_d       = prev_pc_q;
        prev_if_d       = prev_if_q;
        prev_stall_d    = prev_stall_q;
        prev_pcsource_d = prev_pcsource_q;
        id_v_d          = id_v_q;
        exe_v_d         = exe_v_q;
        mem_v_d         = mem_v_q;
        wb_v_d          = wb_v_q;
        cycle_cnt_d     = cycle_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        retire_cnt_d    = retire_cnt_q;
        run_d           = run_q;
        max_run_d       = max_run_q;
        err_d           = err_q;
        err_code_d      = err_code_q;
        err_pc_d        = err_pc_q;

        case (state_q)
            ST_IDLE: begin
                prev_pc_d       = trace.PC;
                prev_if_d       = trace.IF_INST;
                prev_stall_d    = trace.stall;
                prev_pcsource_d = trace.pcsource;
                id_v_d          = 1'b1;
                state_d         = ST_RUN;
            end
            ST_RUN, ST_ERROR: begin
                prev_pc_d       = trace.PC;
                prev_if_d       = trace.IF_INST;
                prev_stall_d    = trace.stall;
                prev_pcsource_d = trace.pcsource;
                // A stall holds the instruction in ID and drops a bubble into EXE
                exe_v_d         = id_v_q & ~trace.stall;
                mem_v_d         = exe_v_q;
                wb_v_d          = mem_v_q;
                cycle_cnt_d     = sat_inc(cycle_cnt_q);
                if (trace.stall) begin
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end
                if (wb_v_q) begin
                    retire_cnt_d = sat_inc(retire_cnt_q);
                end
                if (trace.stall) begin
                    run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
                end else begin
                    run_d = 8'd0;
                end
                max_run_d = (run_d > max_run_q) ? run_d : max_run_q;
                if ((state_q == ST_RUN) && (fail_code != 3'd0)) begin
                    state_d    = ST_ERROR;
                    err_d      = 1'b1;
                    err_code_d = fail_code;
                    err_pc_d   = trace.PC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q         <= ST_IDLE;
            prev_pc_q       <= '0;
            prev_if_q       <= '0;
            prev_stall_q    <= 1'b0;
            prev_pcsource_q <= '0;
            id_v_q          <= 1'b0;
            exe_v_q         <= 1'b0;
            mem_v_q         <= 1'b0;
            wb_v_q          <= 1'b0;
            cycle_cnt_q     <= '0;
            stall_cnt_q     <= '0;
            retire_cnt_q    <= '0;
            run_q           <= '0;
            max_run_q       <= '0;
            err_q           <= 1'b0;
            err_code_q      <= '0;
            err_pc_q        <= '0;
        end else begin
            state_q         <= state_d;
            prev_pc_q       <= prev_pc_d;
            prev_if_q       <= prev_if_d;
            prev_stall_q    <= prev_stall_d;
            prev_pcsource_q <= prev_pcsource_d;
            id_v_q          <= id_v_d;
            exe_v_q         <= exe_v_d;
            mem_v_q         <= mem_v_d;
            wb_v_q          <= wb_v_d;
            cycle_cnt_q     <= cycle_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            retire_cnt_q    <= retire_cnt_d;
            run_q           <= run_d;
            max_run_q       <= max_run_d;
            err_q           <= err_d;
            err_code_q      <= err_code_d;
            err_pc_q        <= err_pc_d;
        end
    end

    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_pc     = err_pc_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign max_run    = max_run_q;

endmodule

// File: tb/tb_ppcpu_trace_checker.sv
// ---------------------------------------------------------------------------
// tb_ppcpu_trace_checker
// Drives directed and randomized CPU trace streams into ppcpu_trace_checker
// and compares its outputs with a trace-level reference model.
// CW is reduced to 8 so counter saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_ppcpu_trace_checker;
    localparam int CW        = 8;
    localparam int MAX_STALL = 3;
    localparam int CNT_SAT   = (1 << CW) - 1;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          err;
    logic [2:0]    err_code;
    logic [31:0]   err_pc;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] retire_cnt;
    logic [7:0]    max_run;

    ppcpu_trace_checker_if trace_if ();

    ppcpu_trace_checker #(.CW(CW), .MAX_STALL(MAX_STALL)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .trace      (trace_if),
        .err        (err),
        .err_code   (err_code),
        .err_pc     (err_pc),
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt),
        .max_run    (max_run)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Trace samples; index 0 is the IDLE cycle, 1..N are RUN cycles
    logic [31:0] q_pc[$];
    logic [31:0] q_if[$];
    logic [31:0] q_id[$];
    logic [1:0]  q_src[$];
    logic        q_stall[$];
    logic        obs_err[$];

    // Model results
    logic        e_err;
    logic [2:0]  e_code;
    logic [31:0] e_pc;
    int          e_cyc, e_stl, e_ret, e_mr;

    // Builds a legal trace of n RUN cycles starting at PC 0. A forced stall
    // run of force_len cycles starting at force_idx may exceed MAX_STALL.
    task automatic build_trace(input int n, input int stall_pct, input int branch_pct,
                               input int force_idx, input int force_len);
        logic [31:0] pc, ifi, id, r;
        logic [1:0]  src;
        logic        st;
        int          run;
        q_pc.delete(); q_if.delete(); q_id.delete(); q_src.delete(); q_stall.delete();
        q_pc.push_back(32'h0); q_if.push_back($urandom); q_id.push_back($urandom);
        q_src.push_back(2'd0); q_stall.push_back(1'b0);
        run = 0;
        for (int i = 1; i <= n; i++) begin
            if (q_stall[i-1]) begin
                pc = q_pc[i-1]; ifi = q_if[i-1]; id = q_id[i-1];
            end else begin
                id  = q_if[i-1];
                ifi = $urandom;
                if (q_src[i-1] == 2'd0) begin
                    pc = q_pc[i-1] + 32'd4;
                end else if ($urandom_range(3) == 0) begin
                    pc = 32'hFFFF_FFF8;
                end else begin
                    r  = $urandom;
                    pc = r & 32'hFFFF_FFFC;
                end
            end
            if (force_idx > 0 && i >= force_idx && i < force_idx + force_len) st = 1'b1;
            else if (force_idx > 0 && i == force_idx + force_len) st = 1'b0;
            else st = (run < MAX_STALL) && (int'($urandom_range(99)) < stall_pct);
            run = st ? run + 1 : 0;
            src = (!st && int'($urandom_range(99)) < branch_pct) ? 2'($urandom_range(3, 1)) : 2'd0;
            q_pc.push_back(pc); q_if.push_back(ifi); q_id.push_back(id);
            q_src.push_back(src); q_stall.push_back(st);
        end
    endtask

    task automatic drive_sample(input int i);
        trace_if.PC       = q_pc[i];
        trace_if.IF_INST  = q_if[i];
        trace_if.ID_INST  = q_id[i];
        trace_if.pcsource = q_src[i];
        trace_if.stall    = q_stall[i];
    endtask

    task automatic drive_random();
        trace_if.PC       = $urandom;
        trace_if.IF_INST  = $urandom;
        trace_if.ID_INST  = $urandom;
        trace_if.pcsource = 2'($urandom_range(3));
        trace_if.stall    = 1'($urandom_range(1));
    endtask

    // Reset for two edges, one IDLE edge, then every RUN sample
    task automatic run_trace();
        int n;
        n = q_pc.size() - 1;
        obs_err.delete();
        Resetn = 1'b0;
        repeat (2) begin drive_random(); @(posedge Clock); #1; end
        Resetn = 1'b1;
        drive_sample(0); @(posedge Clock); #1;
        obs_err.push_back(err);
        for (int i = 1; i <= n; i++) begin
            drive_sample(i); @(posedge Clock); #1;
            obs_err.push_back(err);
        end
    endtask

    // Reference model computed directly from the trace rules
    task automatic model();
        int n, run, code;
        n = q_pc.size() - 1;
        e_err = 1'b0; e_code = 3'd0; e_pc = 32'h0;
        e_cyc = 0; e_stl = 0; e_ret = 0; e_mr = 0; run = 0;
        for (int i = 1; i <= n; i++) begin
            if (e_cyc < CNT_SAT) e_cyc++;
            if (q_stall[i] && e_stl < CNT_SAT) e_stl++;
            // the instruction in ID at cycle k-3 reaches WB in cycle k unless it stalled
            if (i >= 4 && !q_stall[i-3] && e_ret < CNT_SAT) e_ret++;
            run = q_stall[i] ? ((run < 255) ? run + 1 : 255) : 0;
            if (run > e_mr) e_mr = run;
            if (!e_err) begin
                code = 0;
                if (q_stall[i-1] && (q_pc[i] != q_pc[i-1] || q_if[i] != q_if[i-1])) code = 1;
`ifdef TRACE_PC_CHECK_EN
                else if (!q_stall[i-1] && q_src[i-1] == 2'd0 && q_pc[i] != q_pc[i-1] + 32'd4) code = 2;
`endif
                else if (!q_stall[i-1] && q_id[i] != q_if[i-1]) code = 3;
                else if (q_stall[i] && run > MAX_STALL) code = 4;
                if (code != 0) begin
                    e_err = 1'b1; e_code = 3'(code); e_pc = q_pc[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (2) begin drive_random(); @(posedge Clock); #1; end
        n_tests++;
        if (err !== 1'b0 || err_code !== 3'd0 || err_pc !== 32'h0 || cycle_cnt !== '0 ||
            stall_cnt !== '0 || retire_cnt !== '0 || max_run !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: err=%b code=%0d pc=%h cyc=%0d stl=%0d ret=%0d mr=%0d, required all 0",
                     err, err_code, err_pc, cycle_cnt, stall_cnt, retire_cnt, max_run);
        end
        build_trace(2, 0, 0, 0, 0);
        Resetn = 1'b1;
        drive_sample(0); @(posedge Clock); #1;
        n_tests++;
        if (cycle_cnt !== 8'd0) begin
            n_fail++; $display("[TB] FAIL idle_no_count: cycle_cnt=%0d, required 0", cycle_cnt);
        end
        drive_sample(1); @(posedge Clock); #1;
        n_tests++;
        if (cycle_cnt !== 8'd1) begin
            n_fail++; $display("[TB] FAIL first_run_cycle: cycle_cnt=%0d, required 1", cycle_cnt);
        end
    endtask

    task automatic test_clean_stream();
        build_trace(20, 0, 0, 0, 0);
        run_trace();
        n_tests++;
        if (err !== 1'b0 || cycle_cnt !== 8'd20 || retire_cnt !== 8'd17 || stall_cnt !== 8'd0 || max_run !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL clean_stream: err=%b cyc=%0d ret=%0d stl=%0d mr=%0d, required 0/20/17/0/0",
                     err, cycle_cnt, retire_cnt, stall_cnt, max_run);
        end
    endtask

    task automatic test_legal_stall();
        build_trace(20, 0, 0, 4, 1);
        run_trace();
        n_tests++;
        if (err !== 1'b0 || stall_cnt !== 8'd1 || retire_cnt !== 8'd16 || max_run !== 8'd1 || cycle_cnt !== 8'd20) begin
            n_fail++;
            $display("[TB] FAIL legal_stall: err=%b stl=%0d ret=%0d mr=%0d cyc=%0d, required 0/1/16/1/20",
                     err, stall_cnt, retire_cnt, max_run, cycle_cnt);
        end
    endtask

    task automatic test_hold_violation();
        build_trace(12, 0, 0, 4, 1);
        q_pc[5] = 32'h14;
        q_id[8] = ~q_id[8];
        run_trace();
        n_tests++;
        if (obs_err[4] !== 1'b0 || obs_err[5] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hold_latency: err after cycles 4/5 = %b/%b, required 0/1", obs_err[4], obs_err[5]);
        end
        n_tests++;
        if (err !== 1'b1 || err_code !== 3'd1 || err_pc !== 32'h14) begin
            n_fail++;
            $display("[TB] FAIL hold_violation: err=%b code=%0d pc=%h, required 1/1/00000014", err, err_code, err_pc);
        end
        n_tests++;
        if (cycle_cnt !== 8'd12) begin
            n_fail++; $display("[TB] FAIL count_in_error: cycle_cnt=%0d, required 12", cycle_cnt);
        end
    endtask

    task automatic test_stall_run();
        build_trace(12, 0, 0, 4, 4);
        run_trace();
        n_tests++;
        if (obs_err[6] !== 1'b0 || obs_err[7] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_run_latency: err after cycles 6/7 = %b/%b, required 0/1", obs_err[6], obs_err[7]);
        end
        n_tests++;
        if (err_code !== 3'd4 || max_run !== 8'd4 || err_pc !== 32'h10 || stall_cnt !== 8'd4) begin
            n_fail++;
            $display("[TB] FAIL stall_run: code=%0d mr=%0d pc=%h stl=%0d, required 4/4/00000010/4",
                     err_code, max_run, err_pc, stall_cnt);
        end
    endtask

    task automatic test_pc_seq();
        build_trace(10, 0, 0, 0, 0);
        for (int i = 3; i <= 10; i++) q_pc[i] = q_pc[i] + 32'h14;
        run_trace();
`ifdef TRACE_PC_CHECK_EN
        n_tests++;
        if (err !== 1'b1 || err_code !== 3'd2 || err_pc !== 32'h20 || obs_err[3] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pc_seq: err=%b code=%0d pc=%h, required 1/2/00000020", err, err_code, err_pc);
        end
`else
        n_tests++;
        if (err !== 1'b0 || err_code !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL pc_seq_disabled: err=%b code=%0d, required 0/0", err, err_code);
        end
`endif
    endtask

    task automatic test_random();
        int n, j, last;
        for (int it = 0; it < 10; it++) begin
            n = (it == 9) ? 300 : int'($urandom_range(80, 30));
            build_trace(n, 25, 20, 0, 0);
            if ($urandom_range(1) == 1) begin
                j = int'($urandom_range(n, 2));
                case ($urandom_range(3))
                    0: q_pc[j] = q_pc[j] ^ 32'h40;
                    1: q_id[j] = q_id[j] ^ 32'h1;
                    2: q_if[j] = q_if[j] ^ 32'h100;
                    default: begin
                        last = (j + 4 <= n) ? j + 4 : n;
                        for (int k = j; k <= last; k++) begin
                            q_stall[k] = (k < j + 4);
                            q_pc[k] = q_pc[j]; q_if[k] = q_if[j];
                        end
                    end
                endcase
            end
            run_trace();
            model();
            n_tests++;
            if (err !== e_err || err_code !== e_code || err_pc !== e_pc) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_err: err=%b code=%0d pc=%h, required %b/%0d/%h",
                         it, err, err_code, err_pc, e_err, e_code, e_pc);
            end
            n_tests++;
            if (cycle_cnt !== CW'(e_cyc) || stall_cnt !== CW'(e_stl) || retire_cnt !== CW'(e_ret)) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_counters: cyc=%0d stl=%0d ret=%0d, required %0d/%0d/%0d",
                         it, cycle_cnt, stall_cnt, retire_cnt, e_cyc, e_stl, e_ret);
            end
            n_tests++;
            if (max_run !== 8'(e_mr)) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_max_run: mr=%0d, required %0d", it, max_run, e_mr);
            end
        end
        n_tests++;
        if (cycle_cnt !== 8'hFF) begin
            n_fail++; $display("[TB] FAIL cycle_saturation: cycle_cnt=%0d, required 255", cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        build_trace(10, 0, 0, 0, 0);
        q_id[4] = ~q_id[4];
        run_trace();
        Resetn = 1'b0;
        drive_random(); @(posedge Clock); #1;
        n_tests++;
        if (err !== 1'b0 || err_code !== 3'd0 || err_pc !== 32'h0 || cycle_cnt !== '0 ||
            stall_cnt !== '0 || retire_cnt !== '0 || max_run !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_run: err=%b code=%0d pc=%h cyc=%0d stl=%0d ret=%0d mr=%0d, required all 0",
                     err, err_code, err_pc, cycle_cnt, stall_cnt, retire_cnt, max_run);
        end
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b0;
        drive_random();
        test_reset();
        test_clean_stream();
        test_legal_stall();
        test_hold_violation();
        test_stall_run();
        test_pc_seq();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
